tmds_video_timing_ctrl: RTL and testbench
=========================================

// Module: tmds_video_timing_ctrl
// PURPOSE
//  Sequences the three TMDS_encoder channels (blue/green/red) for one video mode.
//  Generates the raster counters, HSYNC/VSYNC and VDE, and fetches pixels from the framebuffer with a fixed-latency request.
//  Drives each encoder's VD/CD/VDE with matched 2-cycle alignment.
//  Sits between the Tetris framebuffer/renderer and the TMDS encoders/serialisers, all in the pixclk domain.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync width (lines)
//  V_BP      33   vertical back porch (lines)
//  HS_POL    0    hsync active level (0 = active-low)
//  VS_POL    0    vsync active level (0 = active-low)
// PORTS
//  pixclk       in   1   pixel clock; the only clock
//  rst          in   1   reset, synchronous, active-high
//  enable       in   1   1 = run video; 0 = stop at the end of the current frame
//  pix_req      out  1   pixel fetch strobe; pix_rgb is returned exactly 1 cycle later
//  pix_x        out  10  pixel column of the request, 0..H_ACTIVE-1
//  pix_y        out  10  pixel row of the request, 0..V_ACTIVE-1
//  pix_rgb      in   24  {R[23:16],G[15:8],B[7:0]}, sampled 1 cycle after pix_req
//  enc_vde      out  1   VDE to all three encoders
//  enc_vd_b     out  8   VD to the blue encoder
//  enc_vd_g     out  8   VD to the green encoder
//  enc_vd_r     out  8   VD to the red encoder
//  enc_cd_b     out  2   CD to the blue encoder = {vsync,hsync}
//  enc_cd_g     out  2   CD to the green encoder, constant 2'b00
//  enc_cd_r     out  2   CD to the red encoder, constant 2'b00
//  frame_start  out  1   1-cycle pulse when counters are (0,0) in RUN
//  active       out  1   1 while in RUN
// BEHAVIOUR
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//    Counters h_cnt/v_cnt are 10 bits; parameters must keep totals <= 1024.
//  - Region order per line and per frame: active, front porch, sync, back porch.
//    hsync is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
//    vsync is active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), for whole lines.
//  - Stage 0 (cycle t): the counters are registered.
//    pix_req = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE && RUN); pix_x = h_cnt; pix_y = v_cnt.
//    All three are registered outputs.
//  - Stage 1 (t+1): pix_rgb is sampled; the raw de/hsync/vsync are delayed by one stage.
//  - Stage 2 (t+2): enc_* outputs are registered.
//    enc_vd_* equal the pix_rgb bytes when enc_vde=1, and 8'h00 otherwise.
//    Sync is applied with its polarity: asserted level = HS_POL/VS_POL.
//  - Total latency from counter to enc_* is 2 cycles; de, hsync and vsync stay mutually aligned.
//  - Counter wrap: h_cnt H_TOTAL-1 -> 0 and v_cnt increments.
//    At (H_TOTAL-1, V_TOTAL-1) both counters go to 0.
//  - FSM IDLE:
//    counters held at 0, pix_req=0.
//    The pipeline keeps flushing with de=0 and sync deasserted.
//    enable=1 -> RUN on the next cycle; the first RUN cycle has (0,0) and frame_start=1.
//  - FSM RUN:
//    counters free-run.
//    At (H_TOTAL-1, V_TOTAL-1): enable=1 -> wrap and stay in RUN (frame_start next cycle); enable=0 -> IDLE.
//    enable dropping mid-frame has no effect until the frame ends; re-raising it before the frame ends cancels the stop.
//  - Reset, including mid-frame: on the next edge
//    - FSM = IDLE, counters = 0, pipeline cleared.
//    - Outputs: pix_req=0, pix_x=pix_y=0, enc_vde=0, enc_vd_*=0, frame_start=0, active=0.
//    - enc_cd_b={~VS_POL,~HS_POL} (2'b11 by default); enc_cd_g=enc_cd_r=2'b00.
//  - enc_cd_* are don't-care to the encoders while enc_vde=1 but must still follow the sync timing.
// TESTING
//  - Reset, then hold enable=0 for 100 cycles:
//    enc_vde=0, pix_req=0, enc_cd_b=2'b11, enc_vd_*=0, active=0 throughout.
//  - Raise enable with pix_rgb=24'hFF8001:
//    - frame_start pulses; pix_req is high for 640 cycles per line and 480 lines per frame.
//    - enc_vde rises 2 cycles after the first pix_req, with enc_vd_r=FF, enc_vd_g=80, enc_vd_b=01.
//  - Line timing:
//    - hsync (enc_cd_b[0]=0) for exactly 96 cycles, starting 16 cycles after the last enc_vde=1.
//    - Line period is 800 cycles.
//    - vsync low for exactly 2 lines, starting 10 lines after the last active line.
//    - Frame period is 420000 cycles.
//  - Fetch latency: return pix_rgb={pix_y[7:0],pix_x[9:2],pix_x[7:0]}.
//    Check enc_vd_* matches the (x,y) requested 2 cycles earlier, including x=639/y=479 and the wrap into line 0.
//  - Stop at frame end: drop enable at (h=100, v=200).
//    The frame completes; IDLE is entered after (799,524); no frame_start follows.
//    Re-raising enable before the frame ends gives a seamless next frame.
//  - Reset mid-frame: assert rst at (h=300, v=100) with enable=1.
//    Next cycle all outputs are at reset values; after release, a fresh frame starts at (0,0) with frame_start=1.

Source files
------------

// File: rtl/tmds_video_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tmds_video_timing_ctrl
//
// Video timing sequencer for one fixed video mode in front of the three TMDS
// encoders (blue/green/red). It generates the raster counters, HSYNC, VSYNC
// and the data-enable. It also fetches pixels from the framebuffer with a
// 1-cycle fixed-latency request, and presents VD/CD/VDE to every encoder on
// the same cycle. Everything runs in the pixclk domain.
//
// Pipeline (one cycle per stage):
//   stage 0 : counters, pix_req/pix_x/pix_y, raw de/hsync/vsync registered
//   stage 1 : framebuffer returns pix_rgb; raw de/hsync/vsync delayed
//   stage 2 : enc_* registered from pix_rgb and the delayed controls
//
// Ports
//   pixclk       in   1   pixel clock, the only clock
//   rst          in   1   synchronous active-high reset
//   enable       in   1   1 = run video, 0 = stop at the end of this frame
//   pix_req      out  1   pixel fetch strobe, pix_rgb is expected 1 cycle later
//   pix_x        out  10  requested column, 0..H_ACTIVE-1 while pix_req=1
//   pix_y        out  10  requested row, 0..V_ACTIVE-1 while pix_req=1
//   pix_rgb      in   24  {R,G,B} returned by the framebuffer
//   enc_vde      out  1   video data enable to all three encoders
//   enc_vd_b/g/r out  8   video data per encoder, 8'h00 outside active video
//   enc_cd_b     out  2   control data to blue encoder = {vsync,hsync}
//   enc_cd_g/r   out  2   control data to green/red encoders, always 2'b00
//   frame_start  out  1   1-cycle pulse when the counters are (0,0) in RUN
//   active       out  1   high while the sequencer is in RUN
// ---------------------------------------------------------------------------
module tmds_video_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        pixclk,
  input  logic        rst,
  input  logic        enable,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  input  logic [23:0] pix_rgb,
  output logic        enc_vde,
  output logic [7:0]  enc_vd_b,
  output logic [7:0]  enc_vd_g,
  output logic [7:0]  enc_vd_r,
  output logic [1:0]  enc_cd_b,
  output logic [1:0]  enc_cd_g,
  output logic [1:0]  enc_cd_r,
  output logic        frame_start,
  output logic        active
);

  // 10-bit versions of the timing boundaries so every compare is width-matched.
  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_q, state_nxt;
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       run_nxt, de_nxt, hs_nxt, vs_nxt, fs_nxt;

  // Stage-1 copies of the raw controls, asserted-high regardless of polarity.
  logic       de_s1, hs_s1, vs_s1;
  // Stage-0 raw controls, aligned with the counters and pix_req.
  logic       de_s0, hs_s0, vs_s0;

  // Next-state and next-counter logic. enable is only looked at when the
  // last pixel of the frame is reached, so dropping and re-raising it
  // mid-frame has no visible effect.
  always_comb begin
    state_nxt = state_q;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    case (state_q)
      IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (h_cnt == H_LAST) begin
          h_nxt = '0;
          if (v_cnt == V_LAST) begin
            v_nxt = '0;
            if (!enable) state_nxt = IDLE;
          end else begin
            v_nxt = v_cnt + 10'd1;
          end
        end else begin
          h_nxt = h_cnt + 10'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        h_nxt     = '0;
        v_nxt     = '0;
      end
    endcase
  end

  // Stage-0 outputs are decoded from the next counter values, so that once
  // registered they line up with the counters in the same cycle.
  always_comb begin
    run_nxt = (state_nxt == RUN);
    de_nxt  = run_nxt && (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
    hs_nxt  = run_nxt && (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
    vs_nxt  = run_nxt && (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
    fs_nxt  = run_nxt && (h_nxt == 10'd0) && (v_nxt == 10'd0);
  end

  // State register, raster counters and the stage-0 fetch request.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      state_q     <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      de_s0       <= 1'b0;
      hs_s0       <= 1'b0;
      vs_s0       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      pix_req     <= de_nxt;
      pix_x       <= h_nxt;
      pix_y       <= v_nxt;
      frame_start <= fs_nxt;
      de_s0       <= de_nxt;
      hs_s0       <= hs_nxt;
      vs_s0       <= vs_nxt;
    end
  end

  // Stage 1: hold the controls for one cycle while the framebuffer answers.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      de_s1 <= 1'b0;
      hs_s1 <= 1'b0;
      vs_s1 <= 1'b0;
    end else begin
      de_s1 <= de_s0;
      hs_s1 <= hs_s0;
      vs_s1 <= vs_s0;
    end
  end

  // Stage 2: register the encoder inputs. pix_rgb is valid in the same cycle
  // as the stage-1 controls, so data and syncs leave together. Sync polarity
  // is only applied here; the pipeline carries asserted-high flags.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      enc_vde  <= 1'b0;
      enc_vd_r <= 8'h00;
      enc_vd_g <= 8'h00;
      enc_vd_b <= 8'h00;
      enc_cd_b <= {~VS_POL, ~HS_POL};
    end else begin
      enc_vde  <= de_s1;
      enc_vd_r <= de_s1 ? pix_rgb[23:16] : 8'h00;
      enc_vd_g <= de_s1 ? pix_rgb[15:8]  : 8'h00;
      enc_vd_b <= de_s1 ? pix_rgb[7:0]   : 8'h00;
      enc_cd_b <= {(vs_s1 ? VS_POL : ~VS_POL), (hs_s1 ? HS_POL : ~HS_POL)};
    end
  end

  assign enc_cd_g = 2'b00;
  assign enc_cd_r = 2'b00;
  assign active   = (state_q == RUN);

endmodule

// File: tb/tb_tmds_video_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tmds_video_timing_ctrl
//
// Directed self-checking bench for tmds_video_timing_ctrl. A reduced video
// mode keeps whole frames short: 16/4/6/4 pixels and 8/2/2/3 lines, giving
// a 30-cycle line and a 450-cycle frame. Expected values come from closed
// form raster positions counted from the first RUN cycle.
// ---------------------------------------------------------------------------
module tb_tmds_video_timing_ctrl;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        pixclk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        pix_req;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_rgb = 24'h0;
  logic        enc_vde;
  logic [7:0]  enc_vd_b, enc_vd_g, enc_vd_r;
  logic [1:0]  enc_cd_b, enc_cd_g, enc_cd_r;
  logic        frame_start, active;

  logic        addr_mode = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  int          last_fs = 0;

  tmds_video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .pixclk(pixclk), .rst(rst), .enable(enable),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .enc_vde(enc_vde), .enc_vd_b(enc_vd_b), .enc_vd_g(enc_vd_g), .enc_vd_r(enc_vd_r),
    .enc_cd_b(enc_cd_b), .enc_cd_g(enc_cd_g), .enc_cd_r(enc_cd_r),
    .frame_start(frame_start), .active(active)
  );

  always #5 pixclk = ~pixclk;

  // Framebuffer model: answers a request one cycle later, either with a
  // constant colour or with data derived from the requested address.
  always @(posedge pixclk) begin
    if (addr_mode)
      pix_rgb <= pix_req ? {pix_y[7:0], pix_x[9:2], pix_x[7:0]} : 24'h0;
    else
      pix_rgb <= 24'hFF8001;
  end

  // Raster model for cycle n counted from the first RUN cycle.
  function automatic int hpos(int n);
    return n % HT;
  endfunction
  function automatic int vpos(int n);
    return (n / HT) % VT;
  endfunction
  function automatic logic is_de(int n);
    return (n >= 0) && (hpos(n) < HA) && (vpos(n) < VA);
  endfunction
  function automatic logic is_hs(int n);
    return (n >= 0) && (hpos(n) >= HA + HF) && (hpos(n) < HA + HF + HS);
  endfunction
  function automatic logic is_vs(int n);
    return (n >= 0) && (vpos(n) >= VA + VF) && (vpos(n) < VA + VF + VS);
  endfunction
  function automatic logic [23:0] addr_rgb(int n);
    logic [9:0] x, y;
    x = 10'(hpos(n));
    y = 10'(vpos(n));
    return {y[7:0], x[9:2], x[7:0]};
  endfunction

  // One clock: wait for the edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge pixclk);
    #1;
    k++;
  endtask

  task automatic advance_to(input int target, output int fs_seen);
    fs_seen = 0;
    while (k < target) begin
      tick();
      if (frame_start === 1'b1 && k != 0) fs_seen++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) tick();
    checks++;
    if ({pix_req, enc_vde, frame_start, active} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got req/vde/fs/act=%b expected 0000",
               {pix_req, enc_vde, frame_start, active});
    end
    checks++;
    if ({pix_x, pix_y} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_xy: got x=%0d y=%0d expected 0 0", pix_x, pix_y);
    end
    checks++;
    if ({enc_cd_b, enc_cd_g, enc_cd_r} !== 6'b110000) begin
      errors++;
      $display("[TB] FAIL reset_cd: got b/g/r=%b expected 110000", {enc_cd_b, enc_cd_g, enc_cd_r});
    end
    checks++;
    if ({enc_vd_r, enc_vd_g, enc_vd_b} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_vd: got %h expected 000000", {enc_vd_r, enc_vd_g, enc_vd_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ({pix_req, enc_vde, active, frame_start, enc_cd_b, enc_vd_r, enc_vd_g, enc_vd_b}
          !== {4'b0000, 2'b11, 24'h0}) begin
        errors++;
        $display("[TB] FAIL idle_outputs cycle %0d: got req=%b vde=%b act=%b fs=%b cd_b=%b vd=%h expected 0 0 0 0 11 000000",
                 i, pix_req, enc_vde, active, frame_start, enc_cd_b, {enc_vd_r, enc_vd_g, enc_vd_b});
      end
    end
  endtask

  task automatic test_first_frame();
    int nreq;
    logic [23:0] exp_vd;
    nreq = 0;
    enable = 1'b1;
    k = -1;
    for (int i = 0; i < FT; i++) begin
      tick();
      if (pix_req === 1'b1) nreq++;
      checks++;
      if (pix_req !== is_de(k) || frame_start !== (k == 0) || active !== 1'b1) begin
        errors++;
        $display("[TB] FAIL frame_ctrl k=%0d: got req=%b fs=%b act=%b expected %b %b 1",
                 k, pix_req, frame_start, active, is_de(k), (k == 0));
      end
      checks++;
      if (pix_x !== 10'(hpos(k)) || pix_y !== 10'(vpos(k))) begin
        errors++;
        $display("[TB] FAIL frame_xy k=%0d: got (%0d,%0d) expected (%0d,%0d)",
                 k, pix_x, pix_y, hpos(k), vpos(k));
      end
      exp_vd = is_de(k - 2) ? 24'hFF8001 : 24'h0;
      checks++;
      if (enc_vde !== is_de(k - 2) || {enc_vd_r, enc_vd_g, enc_vd_b} !== exp_vd) begin
        errors++;
        $display("[TB] FAIL frame_video k=%0d: got vde=%b vd=%h expected %b %h",
                 k, enc_vde, {enc_vd_r, enc_vd_g, enc_vd_b}, is_de(k - 2), exp_vd);
      end
      checks++;
      if (enc_cd_b !== {~is_vs(k - 2), ~is_hs(k - 2)} || {enc_cd_g, enc_cd_r} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL frame_cd k=%0d: got b=%b g=%b r=%b expected %b 00 00",
                 k, enc_cd_b, enc_cd_g, enc_cd_r, {~is_vs(k - 2), ~is_hs(k - 2)});
      end
    end
    checks++;
    if (nreq != HA * VA) begin
      errors++;
      $display("[TB] FAIL frame_req_count: got %0d expected %0d", nreq, HA * VA);
    end
    last_fs = 0;
  endtask

  task automatic test_line_timing();
    int last_vde, hs_fall, vs_fall, hs_pulses, vs_pulses;
    logic prev_hs, prev_vs, hs_low, vs_low, have_fall;
    last_vde = -1000; hs_fall = 0; vs_fall = 0; hs_pulses = 0; vs_pulses = 0;
    prev_hs = 1'b0; prev_vs = 1'b0; have_fall = 1'b0;
    for (int i = 0; i < FT; i++) begin
      tick();
      if (enc_vde === 1'b1) last_vde = k;
      hs_low = (enc_cd_b[0] === 1'b0);
      vs_low = (enc_cd_b[1] === 1'b0);
      if (hs_low && !prev_hs) begin
        if (have_fall) begin
          checks++;
          if (k - hs_fall != HT) begin
            errors++;
            $display("[TB] FAIL line_period: got %0d expected %0d", k - hs_fall, HT);
          end
        end
        if (k - last_vde < HT) begin
          checks++;
          if (k - last_vde - 1 != HF) begin
            errors++;
            $display("[TB] FAIL h_front_porch: got %0d expected %0d", k - last_vde - 1, HF);
          end
        end
        hs_fall = k; have_fall = 1'b1; hs_pulses++;
      end
      if (!hs_low && prev_hs) begin
        checks++;
        if (k - hs_fall != HS) begin
          errors++;
          $display("[TB] FAIL hsync_width: got %0d expected %0d", k - hs_fall, HS);
        end
      end
      if (vs_low && !prev_vs) begin
        checks++;
        if (k - last_vde != (VF + 1) * HT - (HA - 1)) begin
          errors++;
          $display("[TB] FAIL vsync_start: got %0d expected %0d", k - last_vde, (VF + 1) * HT - (HA - 1));
        end
        vs_fall = k; vs_pulses++;
      end
      if (!vs_low && prev_vs) begin
        checks++;
        if (k - vs_fall != VS * HT) begin
          errors++;
          $display("[TB] FAIL vsync_width: got %0d expected %0d", k - vs_fall, VS * HT);
        end
      end
      if (frame_start === 1'b1) begin
        checks++;
        if (k - last_fs != FT) begin
          errors++;
          $display("[TB] FAIL frame_period: got %0d expected %0d", k - last_fs, FT);
        end
        last_fs = k;
      end
      prev_hs = hs_low;
      prev_vs = vs_low;
    end
    checks++;
    if (hs_pulses != VT || vs_pulses != 1) begin
      errors++;
      $display("[TB] FAIL sync_pulse_count: got hs=%0d vs=%0d expected %0d 1", hs_pulses, vs_pulses, VT);
    end
  endtask

  task automatic test_fetch_latency();
    logic [23:0] exp_vd;
    addr_mode = 1'b1;
    while (k < 3 * FT + 5) begin
      tick();
      exp_vd = is_de(k - 2) ? addr_rgb(k - 2) : 24'h0;
      checks++;
      if (enc_vde !== is_de(k - 2) || {enc_vd_r, enc_vd_g, enc_vd_b} !== exp_vd) begin
        errors++;
        $display("[TB] FAIL fetch_data k=%0d (x=%0d,y=%0d): got vde=%b vd=%h expected %b %h",
                 k, hpos(k - 2), vpos(k - 2), enc_vde, {enc_vd_r, enc_vd_g, enc_vd_b},
                 is_de(k - 2), exp_vd);
      end
    end
  endtask

  task automatic test_stop_at_frame_end();
    int base, fs_seen;
    base = 3 * FT;
    advance_to(base + 5 * HT + 10, fs_seen);
    checks++;
    if (pix_x !== 10'd10 || pix_y !== 10'd5) begin
      errors++;
      $display("[TB] FAIL stop_position: got (%0d,%0d) expected (10,5)", pix_x, pix_y);
    end
    enable = 1'b0;
    advance_to(base + FT - 1, fs_seen);
    checks++;
    if (active !== 1'b1 || pix_x !== 10'(HT - 1) || pix_y !== 10'(VT - 1) || fs_seen != 0) begin
      errors++;
      $display("[TB] FAIL stop_last_pixel: got act=%b (%0d,%0d) fs=%0d expected 1 (%0d,%0d) 0",
               active, pix_x, pix_y, fs_seen, HT - 1, VT - 1);
    end
    for (int i = 0; i < 60; i++) begin
      tick();
      checks++;
      if ({active, frame_start, pix_req} !== 3'b000 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
        errors++;
        $display("[TB] FAIL stop_idle cycle %0d: got act=%b fs=%b req=%b (%0d,%0d) expected 0 0 0 (0,0)",
                 i, active, frame_start, pix_req, pix_x, pix_y);
      end
    end
    // Restart, then drop and re-raise enable inside the frame.
    enable = 1'b1;
    k = -1;
    tick();
    checks++;
    if (frame_start !== 1'b1 || active !== 1'b1 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
      errors++;
      $display("[TB] FAIL restart: got fs=%b act=%b (%0d,%0d) expected 1 1 (0,0)",
               frame_start, active, pix_x, pix_y);
    end
    advance_to(5 * HT + 10, fs_seen);
    enable = 1'b0;
    advance_to(10 * HT + 5, fs_seen);
    enable = 1'b1;
    advance_to(FT, fs_seen);
    checks++;
    if (frame_start !== 1'b1 || active !== 1'b1 || pix_x !== 10'd0 || pix_y !== 10'd0 || pix_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL seamless_frame: got fs=%b act=%b req=%b (%0d,%0d) expected 1 1 1 (0,0)",
               frame_start, active, pix_req, pix_x, pix_y);
    end
  endtask

  task automatic test_reset_midframe();
    int fs_seen;
    logic [23:0] exp_vd;
    advance_to(FT + 3 * HT + 11, fs_seen);
    checks++;
    if (pix_x !== 10'd11 || pix_y !== 10'd3 || enc_vde !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midframe_position: got (%0d,%0d) vde=%b expected (11,3) 1", pix_x, pix_y, enc_vde);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({pix_req, enc_vde, frame_start, active} !== 4'b0000 || {pix_x, pix_y} !== 20'h0 ||
        {enc_vd_r, enc_vd_g, enc_vd_b} !== 24'h0 || {enc_cd_b, enc_cd_g, enc_cd_r} !== 6'b110000) begin
      errors++;
      $display("[TB] FAIL midframe_reset: got req/vde/fs/act=%b (%0d,%0d) vd=%h cd=%b expected 0000 (0,0) 000000 110000",
               {pix_req, enc_vde, frame_start, active}, pix_x, pix_y,
               {enc_vd_r, enc_vd_g, enc_vd_b}, {enc_cd_b, enc_cd_g, enc_cd_r});
    end
    rst = 1'b0;
    k = -1;
    tick();
    checks++;
    if (frame_start !== 1'b1 || active !== 1'b1 || pix_req !== 1'b1 || {pix_x, pix_y} !== 20'h0 || enc_vde !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_start: got fs=%b act=%b req=%b (%0d,%0d) vde=%b expected 1 1 1 (0,0) 0",
               frame_start, active, pix_req, pix_x, pix_y, enc_vde);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_vd = is_de(k - 2) ? addr_rgb(k - 2) : 24'h0;
      checks++;
      if (enc_vde !== is_de(k - 2) || {enc_vd_r, enc_vd_g, enc_vd_b} !== exp_vd) begin
        errors++;
        $display("[TB] FAIL post_reset_video k=%0d: got vde=%b vd=%h expected %b %h",
                 k, enc_vde, {enc_vd_r, enc_vd_g, enc_vd_b}, is_de(k - 2), exp_vd);
      end
    end
  endtask

  // Scenarios run back to back on one continuous timeline.
  initial begin
    test_reset();
    test_idle();
    test_first_frame();
    test_line_timing();
    test_fetch_latency();
    test_stop_at_frame_end();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
